// File: rtl/seg7_pkg.sv
// Shared constants and buffer type for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}; every pattern is active-low.
package seg7_pkg;

  // Edit this to match the top-level NUM_DIGITS; it sizes the buffer struct.
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blank_mask;
  } disp_buf_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the scan driver: buffer load inputs and pin outputs.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lzs_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output enable, load, value, dp_mask, blank_mask, lzs_en,
    input  seg, dp, an, frame_done, pending
  );

  modport slave (
    input  enable, load, value, dp_mask, blank_mask, lzs_en,
    output seg, dp, an, frame_done, pending
  );
endinterface

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode display driver with double-buffered frame update,
// blanking, decimal points, leading-zero suppression and anti-ghost dead time.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = seg7_pkg::NUM_DIGITS,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input logic          clk,
  input logic          rst_n,
  seg7_scan_driver_if.slave bus
);
  import seg7_pkg::*;

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankCyc = CntW'(BLANK_CYC);
  localparam logic [DigW-1:0] DigMax   = DigW'(NUM_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DigW-1:0]       digit_q, digit_d;
  disp_buf_t             shadow_q, shadow_d;
  disp_buf_t             active_q, active_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  disp_buf_t             in_buf;
  logic                  tick, wrap;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic                  dp_bit, blank_bit, lead_zero, dark;
  logic [NUM_DIGITS-1:0] an_sel;

  assign in_buf = '{value: bus.value, dp_mask: bus.dp_mask, blank_mask: bus.blank_mask};
  assign tick   = bus.enable && (cnt_q == CntMax);
  assign wrap   = tick && (digit_q == DigMax);

  always_comb begin
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (!bus.enable) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (tick) begin
      cnt_d   = '0;
      digit_d = wrap ? '0 : digit_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (bus.load) shadow_d = in_buf;

    // While idle, or on a load that lands on the wrap tick, bypass the shadow.
    if (!bus.enable) begin
      if (bus.load) begin
        active_d  = in_buf;
        pending_d = 1'b0;
      end
    end else if (wrap) begin
      active_d  = bus.load ? in_buf : shadow_q;
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  // Digit mux plus leading-zero scan from the most significant digit down.
  always_comb begin
    nibble    = 4'h0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    lead_zero = 1'b1;
    an_sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (DigW'(i) == digit_q) begin
        nibble    = active_q.value[4*i +: 4];
        dp_bit    = active_q.dp_mask[i];
        blank_bit = active_q.blank_mask[i];
        an_sel[i] = 1'b1;
      end
      if ((DigW'(i) >= digit_q) && (active_q.value[4*i +: 4] != 4'h0)) lead_zero = 1'b0;
    end
    dark = blank_bit || (bus.lzs_en && lead_zero && (digit_q != '0));
    an_d = (bus.enable && (cnt_q >= BlankCyc)) ? ~an_sel : '1;
  end

  hex7seg_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      digit_q      <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= dark ? SEG_OFF : seg_dec;
      dp_q         <= dark | ~dp_bit;
      an_q         <= an_d;
      frame_done_q <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues the expected {an, seg, dp} of each lit slot,
// a monitor pops one entry whenever an anode first goes low after dead time.
module tb_seg7_scan_driver;
  localparam int unsigned ND = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) dif ();

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned fd_prev = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  prev_an = 4'b1111;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [11:0] e;
    logic [11:0] got;
    got = {dif.an, dif.seg, dif.dp};
    if (dif.an != 4'b1111 && prev_an == 4'b1111) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL slot_unexpected: got an=%b seg=%b dp=%b, no slot expected",
                 dif.an, dif.seg, dif.dp);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL slot: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   got[11:8], got[7:1], got[0], e[11:8], e[7:1], e[0]);
        end
      end
    end
    prev_an = dif.an;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_slot(input int d, input logic [6:0] s, input logic dpl);
    logic [3:0] an_exp;
    an_exp = 4'b1111;
    an_exp[d] = 1'b0;
    exp_q.push_back({an_exp, s, dpl});
  endtask

  // dpn holds the expected active-low dp level for digits 3..0.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpn);
    push_slot(0, s0, dpn[0]);
    push_slot(1, s1, dpn[1]);
    push_slot(2, s2, dpn[2]);
    push_slot(3, s3, dpn[3]);
  endtask

  task automatic wait_fd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dif.frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, int'(seen), 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] blm);
    dif.value      = v;
    dif.dp_mask    = dpm;
    dif.blank_mask = blm;
    dif.load       = 1'b1;
    @(negedge clk);
    dif.load = 1'b0;
  endtask

  initial begin
    bit pend_seen;
    dif.enable     = 1'b0;
    dif.load       = 1'b0;
    dif.value      = '0;
    dif.dp_mask    = '0;
    dif.blank_mask = '0;
    dif.lzs_en     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_seg", int'(dif.seg), 'h7F);
    check("rst_dp", int'(dif.dp), 1);
    check("rst_an", int'(dif.an), 'hF);
    check("rst_frame_done", int'(dif.frame_done), 0);
    check("rst_pending", int'(dif.pending), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 0: all zeros after enable, two dead cycles then digit 0.
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    dif.enable = 1'b1;
    @(negedge clk);
    check("dead_an_0", int'(dif.an), 'hF);
    @(negedge clk);
    check("dead_an_1", int'(dif.an), 'hF);
    @(negedge clk);
    check("first_an", int'(dif.an), 'hE);
    check("first_seg", int'(dif.seg), 'h40);
    wait_fd("fd_frame0");
    fd_prev = cyc;

    // Frame 1: load 12AF during digit 1, committed at the next wrap.
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    repeat (10) @(negedge clk);
    dif.value = 16'h12AF;
    dif.load  = 1'b1;
    @(negedge clk);
    dif.load = 1'b0;
    check("pending_set", int'(dif.pending), 1);
    wait_fd("fd_frame1");
    check("fd_period_1", int'(cyc - fd_prev), 32);
    check("pending_clr", int'(dif.pending), 0);
    fd_prev = cyc;

    // Frame 2 shows 12AF; load 8D6C exactly on its wrap tick.
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b1111);
    repeat (31) @(negedge clk);
    push_frame(7'h46, 7'h02, 7'h21, 7'h00, 4'b1111);
    dif.value = 16'h8D6C;
    dif.load  = 1'b1;
    @(negedge clk);
    dif.load = 1'b0;
    check("fd_on_wrap_load", int'(dif.frame_done), 1);
    check("fd_period_2", int'(cyc - fd_prev), 32);
    pend_seen = 1'b0;
    repeat (24) begin
      if (dif.pending) pend_seen = 1'b1;
      @(negedge clk);
    end
    check("wrap_load_no_pending", int'(pend_seen), 0);

    // Frame 4: 0050 with leading-zero suppression.
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_fd("fd_frame3");
    check("pending_clr_lzs", int'(dif.pending), 0);
    dif.lzs_en = 1'b1;
    push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b1111);
    repeat (20) @(negedge clk);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_fd("fd_frame4");
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);

    // Frame 6: decimal point on digit 2, digit 0 blanked.
    repeat (20) @(negedge clk);
    do_load(16'h4321, 4'b0100, 4'b0001);
    wait_fd("fd_frame5");
    dif.lzs_en = 1'b0;
    push_frame(7'h7F, 7'h24, 7'h30, 7'h19, 4'b1011);
    wait_fd("fd_frame6");

    // Drop enable during digit 1, load while idle, then resume.
    push_slot(0, 7'h7F, 1'b1);
    push_slot(1, 7'h24, 1'b1);
    repeat (13) @(negedge clk);
    dif.enable = 1'b0;
    @(negedge clk);
    check("disable_an", int'(dif.an), 'hF);
    repeat (2) @(negedge clk);
    do_load(16'h9E7B, 4'b0000, 4'b0000);
    check("idle_load_no_pending", int'(dif.pending), 0);
    repeat (4) @(negedge clk);
    push_frame(7'h03, 7'h78, 7'h06, 7'h10, 4'b1111);
    dif.enable = 1'b1;
    fd_prev = cyc;
    @(negedge clk);
    check("resume_dead_0", int'(dif.an), 'hF);
    @(negedge clk);
    check("resume_dead_1", int'(dif.an), 'hF);
    @(negedge clk);
    check("resume_an", int'(dif.an), 'hE);
    check("resume_seg", int'(dif.seg), 'h03);
    wait_fd("fd_resume");
    check("fd_period_resume", int'(cyc - fd_prev), 32);

    // Asynchronous reset mid-slot with a pending load outstanding.
    push_slot(0, 7'h03, 1'b1);
    @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000);
    check("pending_before_rst", int'(dif.pending), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_seg", int'(dif.seg), 'h7F);
    check("arst_dp", int'(dif.dp), 1);
    check("arst_an", int'(dif.an), 'hF);
    check("arst_pending", int'(dif.pending), 0);
    check("arst_frame_done", int'(dif.frame_done), 0);
    repeat (2) @(negedge clk);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    rst_n = 1'b1;
    wait_fd("fd_after_rst");
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a common-anode bank of NUM_DIGITS seven-segment digits, sitting between the Hamming datapath (syndrome, data and error-position nibbles) and the board display pins. It extends the single-nibble decoder to a packed multi-digit value. It adds a double-buffered display register with frame-synchronous update, per-digit blanking and decimal points, leading-zero suppression and anti-ghosting dead time. All segment and anode outputs are active-low.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ 4)
- BLANK_CYC, 16, dead-time cycles at the start of each slot with all anodes off (< REFRESH_DIV)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable; 0 turns all anodes off
- load  in  1  one-cycle strobe that captures value/dp_mask/blank_mask
- value  in  4*NUM_DIGITS  packed hex nibbles; nibble i = value[4i+3:4i], digit 0 rightmost
- dp_mask  in  NUM_DIGITS  1 = light decimal point of digit i
- blank_mask  in  NUM_DIGITS  1 = force digit i dark
- lzs_en  in  1  leading-zero suppression enable (sampled live)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  digit anodes, active-low, at most one low
- frame_done  out  1  one-cycle pulse when digit NUM_DIGITS-1 slot ends
- pending  out  1  shadow buffer holds an uncommitted load

## Operation
- Buffers: load writes shadow {value, dp_mask, blank_mask} and sets pending. At frame wrap (slot tick while digit = NUM_DIGITS-1), shadow is copied to active and pending is cleared. Display always uses active.
- Load coincident with wrap tick: the new inputs go directly to active and pending stays 0.
- enable=0: load writes shadow and active together and pending stays 0. Prescaler and digit index are held at 0 and an is all ones. Scanning restarts at digit 0 slot cycle 0 when enable rises.
- Prescaler cnt counts 0..REFRESH_DIV-1. Tick = (cnt == REFRESH_DIV-1). On tick, digit increments and wraps NUM_DIGITS-1 → 0.
- Dead time: while cnt < BLANK_CYC, an = all ones. Otherwise an[digit] = 0.
- Digit dark if blank_mask_a[digit], or if lzs_en and every nibble from NUM_DIGITS-1 down to and including digit is 0 and digit ≠ 0. Digit 0 is never suppressed. When dark: seg = 7'h7F and dp = 1, but an still strobes.
- Decode: 0–9, A, b, C, d, E, F with active-low patterns, e.g. 0 → 1000000, 8 → 0000000, F → 0001110.
- dp = ~dp_mask_a[digit] unless the digit is dark.

## Timing
- Reset values: cnt 0, digit 0, seg 7'h7F, dp 1, an all ones, frame_done 0, pending 0, shadow/active all 0.
- seg, dp and an are registered. They reflect the cnt/digit/active state of the previous cycle, giving 1-cycle latency.
- frame_done is registered and high the cycle after the wrap tick.
- A newly committed frame first appears on seg in the first non-blank cycle of digit 0 after the wrap.
- Reset assertion mid-scan forces the reset values asynchronously and discards pending.

## Structure
- Package seg7_pkg: segment pattern constants for 0–F, SEG_OFF = 7'h7F, and a packed struct type for the display buffer {value, dp_mask, blank_mask}, parameterised by a NUM_DIGITS localparam override.
- One combinational sub-module, hex7seg_decode (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.
- Top module contains the prescaler, digit counter, buffers, LZS logic and output registers.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
- Reset, then enable=1 with no load → an stays 1111 for 2 cycles, then 1110 with seg=1000000. Digit advances every 8 cycles. frame_done pulses every 32 cycles.
- Load value=16'h12AF mid-frame (digit 1) → pending=1. Digits 1–3 keep showing 0. After wrap, digit 0 shows F (0001110), digit 3 shows 1 (1111001), and pending=0.
- Load coincident with the wrap tick → pending never rises and the new value is shown in the very next digit 0 slot.
- lzs_en=1, value=16'h0050 → digits 3 and 2 have seg=7'h7F with anodes still strobing. Digit 1 shows 5 and digit 0 shows 0. value=0 → only digit 0 lit, showing 0.
- dp_mask=4'b0100, blank_mask=4'b0001 → dp=0 only in digit 2 slot. Digit 0 is dark, with seg=7'h7F and dp=1.
- Drop rst_n mid-slot → outputs return to reset values in the same cycle (asynchronously). Drop enable mid-frame → an=1111 next cycle. Re-enable → scan resumes at digit 0, cnt 0.
